// File: rtl/rvfi_cover_pkg.sv
// Shared definitions for the RVFI event-coverage monitor: class indices and FSM states.
package rvfi_cover_pkg;

   localparam int NUM_CLS    = 6;
   localparam int CLS_DMEMRD = 0;
   localparam int CLS_DMEMWR = 1;
   localparam int CLS_LONG   = 2;
   localparam int CLS_COMPR  = 3;
   localparam int CLS_TRAP   = 4;
   localparam int CLS_NONSEQ = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rvfi_cover_sat_counter.sv
// Saturating per-class event counter with a registered goal flag.
// goal_next exposes the post-update comparison so the parent FSM can stop on the same edge.
module rvfi_cover_sat_counter #(
   parameter int INC_W = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [INC_W-1:0] increment,
   input  logic             inc_en,
   input  logic             clear,
   input  logic [CNT_W-1:0] threshold,
   output logic [CNT_W-1:0] count,
   output logic             goal_met,
   output logic             goal_next
);

   localparam int SUM_W = CNT_W + INC_W;
   localparam logic [SUM_W-1:0] SAT = {{INC_W{1'b0}}, {CNT_W{1'b1}}};

   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] count_next;

   // The sum is widened so the saturation test sees every carry, whatever NRET is.
   always_comb begin
      sum        = {{INC_W{1'b0}}, count} + {{CNT_W{1'b0}}, increment};
      count_next = count;
      if (clear)
         count_next = '0;
      else if (inc_en)
         count_next = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   assign goal_next = (count_next >= threshold);

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         goal_met <= 1'b0;
      end else begin
         count    <= count_next;
         goal_met <= goal_next;
      end
   end

endmodule

// File: rtl/rvfi_cover_monitor.sv
// RVFI event-coverage monitor: classifies retirements, counts per class, tracks goals.
// Define RVFI_COVER_MONITOR_PROPS_EN to emit cover properties and sanity assertions.
module rvfi_cover_monitor
   import rvfi_cover_pkg::*;
#(
   parameter int NRET         = 1,
   parameter int CNT_W        = 8,
   parameter int STOP_ON_GOAL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [NRET-1:0]          rvfi_valid,
   input  logic [32*NRET-1:0]       rvfi_insn,
   input  logic [NRET-1:0]          rvfi_trap,
   input  logic [32*NRET-1:0]       rvfi_pc_rdata,
   input  logic [32*NRET-1:0]       rvfi_pc_wdata,
   input  logic [4*NRET-1:0]        rvfi_mem_rmask,
   input  logic [4*NRET-1:0]        rvfi_mem_wmask,
   input  logic [NUM_CLS*CNT_W-1:0] goal_thresh,
   output logic [NUM_CLS*CNT_W-1:0] cnt,
   output logic [NUM_CLS-1:0]       goal_met,
   output logic                     all_met,
   output logic [1:0]               state
);

   localparam int INC_W = $clog2(NRET + 1);

   state_t             state_q;
   state_t             state_d;
   logic [NUM_CLS-1:0] hits [NRET];
   logic [INC_W-1:0]   inc  [NUM_CLS];
   logic [NUM_CLS-1:0] goal_next;
   logic               count_en;
   logic               unused_insn_bits;

   // Only the length field of the instruction word matters for classification.
   assign unused_insn_bits = ^rvfi_insn;

   for (genvar c = 0; c < NRET; c++) begin : g_chan
      logic               is_long;
      logic [31:0]        seq_pc;
      logic [NUM_CLS-1:0] ch_hit;

      assign is_long = (rvfi_insn[32*c +: 2] == 2'b11);
      assign seq_pc  = rvfi_pc_rdata[32*c +: 32] + (is_long ? 32'd4 : 32'd2);

      always_comb begin
         ch_hit             = '0;
         ch_hit[CLS_DMEMRD] = rvfi_mem_rmask[4*c +: 4] != 4'd0;
         ch_hit[CLS_DMEMWR] = rvfi_mem_wmask[4*c +: 4] != 4'd0;
         ch_hit[CLS_LONG]   = is_long;
         ch_hit[CLS_COMPR]  = !is_long;
         ch_hit[CLS_TRAP]   = rvfi_trap[c];
         ch_hit[CLS_NONSEQ] = !rvfi_trap[c] && (rvfi_pc_wdata[32*c +: 32] != seq_pc);
         if (!rvfi_valid[c])
            ch_hit = '0;
      end

      assign hits[c] = ch_hit;
   end

   always_comb begin
      for (int k = 0; k < NUM_CLS; k++)
         inc[k] = '0;
      for (int c = 0; c < NRET; c++)
         for (int k = 0; k < NUM_CLS; k++)
            inc[k] = inc[k] + INC_W'(hits[c][k]);
   end

   assign count_en = (state_q == RUN);

   for (genvar k = 0; k < NUM_CLS; k++) begin : g_cls
      rvfi_cover_sat_counter #(
         .INC_W (INC_W),
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .increment (inc[k]),
         .inc_en    (count_en),
         .clear     (clear),
         .threshold (goal_thresh[k*CNT_W +: CNT_W]),
         .count     (cnt[k*CNT_W +: CNT_W]),
         .goal_met  (goal_met[k]),
         .goal_next (goal_next[k])
      );
   end

   assign all_met = &goal_met;

   // Stopping uses the post-update goal vector so no retire slips in after the last goal.
   always_comb begin
      state_d = state_q;
      if (clear)
         state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN: begin
               if ((STOP_ON_GOAL != 0) && (&goal_next))
                  state_d = DONE;
               else if (!enable)
                  state_d = IDLE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   assign state = state_q;

`ifdef RVFI_COVER_MONITOR_PROPS_EN
   for (genvar k = 0; k < NUM_CLS; k++) begin : g_props
      cov_goal: cover property (@(posedge clk) goal_met[k]);
      ast_no_decrease: assert property (@(posedge clk) disable iff (reset)
         !clear |=> (cnt[k*CNT_W +: CNT_W] >= $past(cnt[k*CNT_W +: CNT_W])));
   end
   cov_all_met: cover property (@(posedge clk) all_met);
   cov_done: cover property (@(posedge clk) state_q == DONE);
   ast_state_legal: assert property (@(posedge clk) state != 2'd3);
`else
`endif

endmodule
